timer_counter_n: RTL and testbench
==================================

Name: timer_counter_n

Overview:
Parametrised successor timer/counter with N BCD digits and a multiplexed seven-segment display. It is fully synchronous: all state runs on clk with clock enables, and there are no derived or ripple clocks. It adds up/down counting, preset load, and a countdown alarm. It sits at the top of the display datapath, driven directly by board buttons.

Parameters:
DIGITS, 4, number of BCD digits and digit-select lines (2..8)
TICK_DIV, 1000, clk cycles per auto-count tick (1 Hz at 1 kHz clk); even, >=4
DEB_LEN, 8, consecutive identical samples required by the button debouncer
SCAN_DIV, 1, clk cycles per display-scan step

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
inv  in  1  output polarity select
mode  in  1  button: toggle manual/auto
start  in  1  button: manual step / auto run
stop  in  1  button: auto pause / alarm clear
load  in  1  button: load preset
dir  in  1  level: 0 = count up, 1 = count down
preset  in  4*DIGITS  BCD preset value, digit 0 in LSBs
count  out  4*DIGITS  current BCD value
running  out  1  high in AUTO_RUN
alarm  out  1  high in ALARM
segment  out  8  {dp,g,f,e,d,c,b,a}; dp always off
digit  out  DIGITS  digit enables

Behaviour:
- Reset (rst=0, async):
  - count=0, state=MANUAL, prescaler=0, blink phase=0, scan index=0, alarm=0, running=0.
  - Debouncer shift registers cleared to 0.
- Debounce (per button):
  - Shift register samples the pin each clk.
  - Debounced level goes to 1 when DEB_LEN samples are all 1, and to 0 when all are 0.
  - A one-cycle pulse is generated on the debounced rising edge.
  - The state/count update occurs on the edge after the pulse.
  - Holding a button yields exactly one pulse.
- FSM states: MANUAL, AUTO_STOP, AUTO_RUN, ALARM.
- Pulse priority in the same cycle: load > stop > mode > start.
  - load: any state. count <= preset, with each nibble >9 clamped to 9. ALARM -> AUTO_STOP; other states unchanged.
  - stop: AUTO_RUN -> AUTO_STOP; ALARM -> AUTO_STOP. Ignored in other states.
  - mode: MANUAL -> AUTO_STOP. AUTO_STOP/AUTO_RUN/ALARM -> MANUAL, and alarm clears.
  - start in MANUAL: count steps once in direction dir.
  - start in AUTO_STOP: -> AUTO_RUN and prescaler cleared to 0.
  - start is ignored in AUTO_RUN and ALARM.
- Tick generation:
  - Prescaler runs only in AUTO_RUN: 0..TICK_DIV-1, then wraps to 0.
  - A tick occurs on the cycle the prescaler equals TICK_DIV-1.
  - The first tick arrives TICK_DIV cycles after entering AUTO_RUN.
- Counting arithmetic (BCD, per-digit carry/borrow chain, single cycle):
  - Up: 9 rolls to 0 with carry. All-9s wraps to all-0s in every mode.
  - Down: 0 rolls to 9 with borrow. In MANUAL, all-0s wraps to all-9s.
  - Down, AUTO_RUN, tick while count==0: count holds at 0 and state -> ALARM on that edge. The count reaching 0 does not itself alarm; only the next tick does.
  - Up-count in AUTO_RUN never alarms.
  - A dir change takes effect on the next step.
- Blink:
  - Free-running toggle every TICK_DIV/2 cycles, cleared at reset.
  - In AUTO_STOP and ALARM, the display is blanked while the phase is 1.
  - MANUAL and AUTO_RUN display steadily.
- Scan:
  - Index advances every SCAN_DIV cycles, 0..DIGITS-1, then wraps.
  - Index k shows count nibble k.
- Outputs (segment and digit are combinational from registered state):
  - inv=0: segments active-high, digit enable active-low (~(1<<k)). inv=1: both inverted.
  - Blanked means all segments off and no digit enabled.
  - Decode table: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F (active-high, dp=0).
- Reset asserted mid-operation aborts immediately; no pulse survives reset.

Decomposition:
- Package timer_pkg:
  - FSM state enum
  - seven-segment decode constant array
  - BCD_MAX=4'd9
  - digit-width localparam helpers
- One sub-module btn_debounce (params DEB_LEN; ports clk, rst, btn, level, pulse), instantiated four times.
- BCD chain, FSM, prescaler, blink and scan are in the top module.

Test Plan (DIGITS=4, TICK_DIV=10, DEB_LEN=4, SCAN_DIV=1):
1. Reset, then 3 manual start presses, dir=0 -> count=0x0003, state MANUAL; a 2-cycle glitch on start -> no change.
2. load with preset=0x0999, then 1 manual start, dir=0 -> count=0x1000; load preset=0x9999 + start -> 0x0000; preset=0x00AF -> loads 0x0099.
3. mode, start, dir=1, preset 0x0002 loaded -> running=1; after 10 cycles 0x0001, after 20 cycles 0x0000, tick at 30 cycles -> alarm=1, count=0x0000; stop -> AUTO_STOP, alarm=0.
4. Same-cycle stop+start pulses in AUTO_RUN -> AUTO_STOP; mode in AUTO_RUN -> MANUAL, prescaler frozen, count held.
5. Scan check: count=0x1234, inv=0 -> digit cycles 1110,1101,1011,0111 with segment 0x66,0x4F,0x5B,0x06; inv=1 -> 0001.. with segment ~0x66..; AUTO_STOP -> 5-cycle blank windows.
6. rst low mid AUTO_RUN with count=0x0042 -> immediately count=0, alarm=0, running=0, digit 0 shows 0x3F.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD timer/counter: FSM states,
// seven-segment decode table and small width/clamp helpers.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_MANUAL    = 2'd0,
        ST_AUTO_STOP = 2'd1,
        ST_AUTO_RUN  = 2'd2,
        ST_ALARM     = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-high {dp,g,f,e,d,c,b,a}, dp always off
    localparam logic [7:0] SEG_TABLE [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
        if (nib > BCD_MAX) return BCD_MAX;
        else               return nib;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        if (nib > BCD_MAX) return 8'h00;
        else               return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/timer_counter_n_btn_debounce.sv
// Button debouncer: level changes only after DEB_LEN identical samples,
// with a single-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DEB_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);

    logic [DEB_LEN-1:0] shift_r;
    logic               level_r;
    logic               pulse_r;
    logic               all_one_s;
    logic               all_zero_s;

    assign all_one_s  = &shift_r;
    assign all_zero_s = ~|shift_r;

    // Sample history, debounced level and rising-edge pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r <= '0;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            shift_r <= {shift_r[DEB_LEN-2:0], btn};
            pulse_r <= all_one_s & ~level_r;
            if (all_one_s)
                level_r <= 1'b1;
            else if (all_zero_s)
                level_r <= 1'b0;
            else
                level_r <= level_r;
        end
    end

    assign level = level_r;
    assign pulse = pulse_r;

endmodule

// File: rtl/timer_counter_n.sv
// N-digit BCD up/down timer/counter with preset load, countdown alarm and a
// multiplexed, blink-capable seven-segment display driver.
module timer_counter_n
    import timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1000,
    parameter int DEB_LEN  = 8,
    parameter int SCAN_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inv,
    input  logic                  mode,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load,
    input  logic                  dir,
    input  logic [4*DIGITS-1:0]   preset,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  alarm,
    output logic [7:0]            segment,
    output logic [DIGITS-1:0]     digit
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = cnt_width(TICK_DIV);
    localparam int BW = cnt_width(TICK_DIV / 2);
    localparam int SW = cnt_width(DIGITS);
    localparam int DW = cnt_width(SCAN_DIV);

    state_e           state_r, state_n;
    logic [CW-1:0]    count_r, count_n;
    logic [PW-1:0]    presc_r, presc_n;
    logic [BW-1:0]    blink_cnt_r;
    logic             blink_r;
    logic [SW-1:0]    scan_r;
    logic [DW-1:0]    scan_div_r;
    logic             running_r, alarm_r;
    logic [3:0]       btn_level_s;
    logic             mode_p_s, start_p_s, stop_p_s, load_p_s;
    logic             tick_s;
    logic             blank_s;
    logic [3:0]       nib_s;
    logic [7:0]       seg_s;
    logic [DIGITS-1:0] dig_s;

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_mode  (.clk(clk), .rst(rst), .btn(mode),  .level(btn_level_s[0]), .pulse(mode_p_s));
    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_start (.clk(clk), .rst(rst), .btn(start), .level(btn_level_s[1]), .pulse(start_p_s));
    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_stop  (.clk(clk), .rst(rst), .btn(stop),  .level(btn_level_s[2]), .pulse(stop_p_s));
    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_load  (.clk(clk), .rst(rst), .btn(load),  .level(btn_level_s[3]), .pulse(load_p_s));

    // One BCD step with a ripple carry/borrow chain; all-9s/all-0s wrap naturally
    function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] val, input logic down);
        logic [CW-1:0] res;
        logic          cy;
        logic [3:0]    nib;
        res = val;
        cy  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = val[4*i +: 4];
            if (!cy) begin
                res[4*i +: 4] = nib;
            end else if (down) begin
                if (nib == 4'd0) begin
                    res[4*i +: 4] = BCD_MAX;
                    cy = 1'b1;
                end else begin
                    res[4*i +: 4] = nib - 4'd1;
                    cy = 1'b0;
                end
            end else begin
                if (nib >= BCD_MAX) begin
                    res[4*i +: 4] = 4'd0;
                    cy = 1'b1;
                end else begin
                    res[4*i +: 4] = nib + 4'd1;
                    cy = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [CW-1:0] preset_clamp(input logic [CW-1:0] val);
        logic [CW-1:0] res;
        res = '0;
        for (int i = 0; i < DIGITS; i++) res[4*i +: 4] = bcd_clamp(val[4*i +: 4]);
        return res;
    endfunction

    assign tick_s = (state_r == ST_AUTO_RUN) && (presc_r == PW'(TICK_DIV - 1));

    // Next state, count and prescaler; a single highest-priority pulse wins
    always_comb begin
        state_n = state_r;
        count_n = count_r;
        if (state_r == ST_AUTO_RUN) presc_n = tick_s ? '0 : presc_r + 1'b1;
        else                        presc_n = presc_r;

        if (load_p_s) begin
            count_n = preset_clamp(preset);
            if (state_r == ST_ALARM) state_n = ST_AUTO_STOP;
            else                     state_n = state_r;
        end else if (stop_p_s) begin
            case (state_r)
                ST_AUTO_RUN, ST_ALARM: state_n = ST_AUTO_STOP;
                default:               state_n = state_r;
            endcase
        end else if (mode_p_s) begin
            case (state_r)
                ST_MANUAL: state_n = ST_AUTO_STOP;
                default:   state_n = ST_MANUAL;
            endcase
        end else if (start_p_s) begin
            case (state_r)
                ST_MANUAL:    count_n = bcd_step(count_r, dir);
                ST_AUTO_STOP: begin
                    state_n = ST_AUTO_RUN;
                    presc_n = '0;
                end
                default:      state_n = state_r;
            endcase
        end else if (tick_s) begin
            // Countdown alarms on the tick after reaching zero, holding at zero
            if (dir && (count_r == '0)) state_n = ST_ALARM;
            else                        count_n = bcd_step(count_r, dir);
        end else begin
            state_n = state_r;
        end
    end

    // Control state, count and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_MANUAL;
            count_r   <= '0;
            presc_r   <= '0;
            running_r <= 1'b0;
            alarm_r   <= 1'b0;
        end else begin
            state_r   <= state_n;
            count_r   <= count_n;
            presc_r   <= presc_n;
            running_r <= (state_n == ST_AUTO_RUN);
            alarm_r   <= (state_n == ST_ALARM);
        end
    end

    // Free-running blink phase and display scan index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
            scan_div_r  <= '0;
            scan_r      <= '0;
        end else begin
            if (blink_cnt_r == BW'(TICK_DIV / 2 - 1)) begin
                blink_cnt_r <= '0;
                blink_r     <= ~blink_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + 1'b1;
            end
            if (scan_div_r == DW'(SCAN_DIV - 1)) begin
                scan_div_r <= '0;
                scan_r     <= (scan_r == SW'(DIGITS - 1)) ? '0 : scan_r + 1'b1;
            end else begin
                scan_div_r <= scan_div_r + 1'b1;
            end
        end
    end

    // Display decode with blanking and polarity select
    always_comb begin
        nib_s   = count_r[{scan_r, 2'b00} +: 4];
        blank_s = blink_r && ((state_r == ST_AUTO_STOP) || (state_r == ST_ALARM));
        seg_s   = 8'h00;
        dig_s   = '1;
        if (!blank_s) begin
            seg_s = seg_decode(nib_s);
            dig_s = ~(DIGITS'(1) << scan_r);
        end else begin
            seg_s = 8'h00;
            dig_s = '1;
        end
        segment = inv ? ~seg_s : seg_s;
        digit   = inv ? ~dig_s : dig_s;
    end

    assign count   = count_r;
    assign running = running_r;
    assign alarm   = alarm_r;

endmodule

// File: tb/tb_timer_counter_n.sv
// Directed bench for timer_counter_n (DIGITS=4, TICK_DIV=10, DEB_LEN=4,
// SCAN_DIV=1); expected values are hand-computed constants.
module tb_timer_counter_n;

    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                inv, mode, start, stop, load, dir;
    logic [4*DIGITS-1:0] preset;
    logic [4*DIGITS-1:0] count;
    logic                running, alarm;
    logic [7:0]          segment;
    logic [DIGITS-1:0]   digit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_counter_n #(
        .DIGITS(4), .TICK_DIV(10), .DEB_LEN(4), .SCAN_DIV(1)
    ) dut (
        .clk(clk), .rst(rst), .inv(inv), .mode(mode), .start(start),
        .stop(stop), .load(load), .dir(dir), .preset(preset),
        .count(count), .running(running), .alarm(alarm),
        .segment(segment), .digit(digit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // btns = {load, stop, mode, start}; held long enough to debounce, then released
    task automatic press(input logic [3:0] btns);
        {load, stop, mode, start} = btns;
        cyc(8);
        {load, stop, mode, start} = 4'b0000;
        cyc(8);
    endtask

    // Locks onto digit 0 (bounded wait), then checks four scan steps of 0x1234
    task automatic scan_check(input logic inv_v);
        logic [3:0] exp_dig [4];
        logic [7:0] exp_seg [4];
        logic [3:0] first;
        int n;
        exp_dig = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{8'h66, 8'h4F, 8'h5B, 8'h06};
        first = inv_v ? 4'b0001 : 4'b1110;
        n = 0;
        while (digit !== first && n < 10) begin
            cyc(1);
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            check(inv_v ? "scan_dig_inv" : "scan_dig", {28'd0, digit},
                  {28'd0, (inv_v ? ~exp_dig[k] : exp_dig[k])});
            check(inv_v ? "scan_seg_inv" : "scan_seg", {24'd0, segment},
                  {24'd0, (inv_v ? ~exp_seg[k] : exp_seg[k])});
            cyc(1);
        end
    endtask

    initial begin
        int blank_cnt, run_len, max_run;
        rst = 1'b0; inv = 1'b0; dir = 1'b0; preset = 16'h0000;
        {load, stop, mode, start} = 4'b0000;
        cyc(3);
        check("rst_count", {16'd0, count}, 32'h0000);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_alarm", {31'd0, alarm}, 32'd0);
        rst = 1'b1;
        cyc(2);

        // Manual stepping and glitch rejection
        for (int i = 0; i < 3; i++) press(4'b0001);
        check("man_count3", {16'd0, count}, 32'h0003);
        check("man_running", {31'd0, running}, 32'd0);
        start = 1'b1; cyc(2); start = 1'b0; cyc(8);
        check("glitch", {16'd0, count}, 32'h0003);

        // Preset load, carry chain, wraps and clamping
        preset = 16'h0999; press(4'b1000);
        check("load_0999", {16'd0, count}, 32'h0999);
        press(4'b0001);
        check("carry_1000", {16'd0, count}, 32'h1000);
        preset = 16'h9999; press(4'b1000); press(4'b0001);
        check("wrap_up", {16'd0, count}, 32'h0000);
        dir = 1'b1; press(4'b0001);
        check("wrap_down", {16'd0, count}, 32'h9999);
        dir = 1'b0;
        preset = 16'h00AF; press(4'b1000);
        check("clamp", {16'd0, count}, 32'h0099);

        // Countdown to alarm, then clear with stop
        preset = 16'h0002; press(4'b1000);
        dir = 1'b1;
        press(4'b0010);
        check("astop_running", {31'd0, running}, 32'd0);
        start = 1'b1; cyc(6);
        check("run_running", {31'd0, running}, 32'd1);
        cyc(2); start = 1'b0; cyc(7);
        check("pre_tick1", {16'd0, count}, 32'h0002);
        cyc(1);
        check("tick1", {16'd0, count}, 32'h0001);
        cyc(10);
        check("tick2", {16'd0, count}, 32'h0000);
        check("no_alarm_at_zero", {31'd0, alarm}, 32'd0);
        cyc(9);
        check("pre_alarm", {31'd0, alarm}, 32'd0);
        cyc(1);
        check("alarm", {31'd0, alarm}, 32'd1);
        check("alarm_count", {16'd0, count}, 32'h0000);
        check("alarm_running", {31'd0, running}, 32'd0);
        press(4'b0100);
        check("alarm_clear", {31'd0, alarm}, 32'd0);

        // Priority and leaving AUTO_RUN
        dir = 1'b0; preset = 16'h0050; press(4'b1000);
        press(4'b0001);
        check("run2_running", {31'd0, running}, 32'd1);
        check("run2_count", {16'd0, count}, 32'h0051);
        press(4'b0101);
        check("stop_wins", {31'd0, running}, 32'd0);
        check("stop_count", {16'd0, count}, 32'h0051);
        press(4'b0001);
        check("run3_count", {16'd0, count}, 32'h0052);
        press(4'b0010);
        check("mode_running", {31'd0, running}, 32'd0);
        cyc(20);
        check("frozen_count", {16'd0, count}, 32'h0052);

        // Display scan and blanking
        preset = 16'h1234; press(4'b1000);
        scan_check(1'b0);
        inv = 1'b1;
        scan_check(1'b1);
        inv = 1'b0;
        press(4'b0010);
        blank_cnt = 0; run_len = 0; max_run = 0;
        for (int i = 0; i < 20; i++) begin
            if (digit === 4'b1111 && segment === 8'h00) begin
                blank_cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            cyc(1);
        end
        check("blank_cnt", blank_cnt, 32'd10);
        check("blank_run", max_run, 32'd5);

        // Reset mid AUTO_RUN
        preset = 16'h0042; press(4'b1000);
        start = 1'b1; cyc(8); start = 1'b0; cyc(2);
        check("pre_rst_count", {16'd0, count}, 32'h0042);
        check("pre_rst_running", {31'd0, running}, 32'd1);
        start = 1'b1;
        rst = 1'b0;
        #1;
        check("mid_rst_count", {16'd0, count}, 32'h0000);
        check("mid_rst_running", {31'd0, running}, 32'd0);
        check("mid_rst_alarm", {31'd0, alarm}, 32'd0);
        check("mid_rst_digit", {28'd0, digit}, 32'b1110);
        check("mid_rst_seg", {24'd0, segment}, 32'h3F);
        cyc(3);
        start = 1'b0;
        rst = 1'b1;
        cyc(10);
        check("post_rst_count", {16'd0, count}, 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
